// File: rtl/test_countdown_timer.sv
// Typing-test countdown timer: 1 Hz decrement, M:SS digits, status.
// Optional blink of the display near expiry with `define TIMER_BLINK_EN.
module test_countdown_timer #(
  parameter int unsigned DEFAULT_SECS = 60,
  parameter int unsigned MAX_SECS     = 599,
  parameter int unsigned WARN_SECS    = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       blink_toggle,
  input  logic       start,
  input  logic       pause,
  input  logic       load,
  input  logic [9:0] load_secs,
  output logic [9:0] secs_remaining,
  output logic [3:0] dig_min,
  output logic [2:0] dig_sec_tens,
  output logic [3:0] dig_sec_ones,
  output logic       running,
  output logic       expired,
  output logic       done_pulse,
  output logic       warn
`ifdef TIMER_BLINK_EN
  ,
  output logic       blank
`endif
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUNNING = 2'd1;
  localparam logic [1:0] PAUSED  = 2'd2;
  localparam logic [1:0] EXPIRED = 2'd3;

  localparam logic [9:0] DEF_V  = 10'(DEFAULT_SECS);
  localparam logic [9:0] MAX_V  = 10'(MAX_SECS);
  localparam logic [9:0] WARN_V = 10'(WARN_SECS);

  localparam logic [9:0] DEF_REM = DEF_V % 10'd60;
  localparam logic [3:0] DEF_MIN = 4'(DEF_V / 10'd60);
  localparam logic [2:0] DEF_TEN = 3'(DEF_REM / 10'd10);
  localparam logic [3:0] DEF_ONE = 4'(DEF_REM % 10'd10);

  logic [1:0] state_q, state_d;
  logic [9:0] secs_q, secs_d;
  logic [3:0] min_q, min_d;
  logic [2:0] ten_q, ten_d;
  logic [3:0] one_q, one_d;
  logic       done_q, done_d;
  logic       warn_q, warn_d;
  logic       start_q, pause_q;

  logic       start_rise, pause_rise;
  logic [9:0] ld_v, ld_rem;
  logic [3:0] ld_min, ld_one;
  logic [2:0] ld_ten;

  assign start_rise = start & ~start_q;
  assign pause_rise = pause & ~pause_q;

  // Clamp the load value and split it into M:SS in one cycle
  always_comb begin
    if (load_secs == 10'd0) begin
      ld_v = DEF_V;
    end else if (load_secs > MAX_V) begin
      ld_v = MAX_V;
    end else begin
      ld_v = load_secs;
    end
    ld_rem = ld_v % 10'd60;
    ld_min = 4'(ld_v / 10'd60);
    ld_ten = 3'(ld_rem / 10'd10);
    ld_one = 4'(ld_rem % 10'd10);
  end

  // State machine, count and cascaded digit down-counters
  always_comb begin
    state_d = state_q;
    secs_d  = secs_q;
    min_d   = min_q;
    ten_d   = ten_q;
    one_d   = one_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          secs_d = ld_v;
          min_d  = ld_min;
          ten_d  = ld_ten;
          one_d  = ld_one;
        end else if (start_rise && secs_q != 10'd0) begin
          state_d = RUNNING;
        end
      end
      RUNNING: begin
        if (pause_rise) begin
          state_d = PAUSED;
        end else if (tick_1hz && secs_q != 10'd0) begin
          secs_d = secs_q - 10'd1;
          if (one_q != 4'd0) begin
            one_d = one_q - 4'd1;
          end else begin
            one_d = 4'd9;
            if (ten_q != 3'd0) begin
              ten_d = ten_q - 3'd1;
            end else begin
              ten_d = 3'd5;
              min_d = min_q - 4'd1;
            end
          end
          if (secs_q == 10'd1) begin
            state_d = EXPIRED;
            done_d  = 1'b1;
          end
        end
      end
      PAUSED: begin
        if (start_rise || pause_rise) begin
          state_d = RUNNING;
        end
      end
      EXPIRED: begin
        if (load) begin
          state_d = IDLE;
          secs_d  = ld_v;
          min_d   = ld_min;
          ten_d   = ld_ten;
          one_d   = ld_one;
        end
      end
      default: state_d = IDLE;
    endcase
    warn_d = (state_d == RUNNING || state_d == PAUSED)
           && (secs_d <= WARN_V);
  end

  // Registered state, count, digits and edge-detect history
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      secs_q  <= DEF_V;
      min_q   <= DEF_MIN;
      ten_q   <= DEF_TEN;
      one_q   <= DEF_ONE;
      done_q  <= 1'b0;
      warn_q  <= 1'b0;
      start_q <= 1'b0;
      pause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      secs_q  <= secs_d;
      min_q   <= min_d;
      ten_q   <= ten_d;
      one_q   <= one_d;
      done_q  <= done_d;
      warn_q  <= warn_d;
      start_q <= start;
      pause_q <= pause;
    end
  end

`ifdef TIMER_BLINK_EN
  logic blink_q;
  logic blank_q, blank_d;

  // Flash the display while warning or after expiry
  always_comb begin
    blank_d = 1'b0;
    if (state_d == EXPIRED ||
        (state_d == RUNNING && warn_d)) begin
      blank_d = blank_q ^ (blink_toggle ^ blink_q);
    end
  end

  // Blink edge history and blank state
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_q <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      blink_q <= blink_toggle;
      blank_q <= blank_d;
    end
  end

  assign blank = blank_q;
`else
  logic unused_blink;
  assign unused_blink = blink_toggle;
`endif

  assign secs_remaining = secs_q;
  assign dig_min        = min_q;
  assign dig_sec_tens   = ten_q;
  assign dig_sec_ones   = one_q;
  assign running        = (state_q == RUNNING);
  assign expired        = (state_q == EXPIRED);
  assign done_pulse     = done_q;
  assign warn           = warn_q;

endmodule

// File: doc/test_countdown_timer.md
Name: test_countdown_timer

Overview:
- Consumes the divider's tick interface and counts down the typing-test time limit.
- Inputs are the one-cycle 1 Hz pulse and the slow square-wave toggle; all logic runs in the 100 MHz system clock domain.
- Produces remaining seconds in binary and in display-ready digits (M:SS) for the 7-segment driver, plus run/pause/expired status and a one-cycle done pulse for the test controller.

Parameters:
- DEFAULT_SECS, 60, value loaded at reset and when load_secs is 0
- MAX_SECS, 599, clamp limit for loaded values (9:59); must be ≤ 1023
- WARN_SECS, 10, remaining-time threshold for the warning/blink behaviour

Ports:
- clk  in  1  100 MHz system clock
- reset  in  1  synchronous, active-high
- tick_1hz  in  1  one-cycle pulse, once per second
- blink_toggle  in  1  slow square wave (toggles every 0.25 s); edges are detected internally
- start  in  1  level; sampled as rising edge
- pause  in  1  level; sampled as rising edge
- load  in  1  one-cycle load strobe
- load_secs  in  10  seconds value for load
- secs_remaining  out  10  binary remaining seconds
- dig_min  out  4  minutes digit, 0-9
- dig_sec_tens  out  3  tens-of-seconds digit, 0-5
- dig_sec_ones  out  4  ones-of-seconds digit, 0-9
- running  out  1  high in RUNNING
- expired  out  1  high in EXPIRED
- done_pulse  out  1  one-cycle pulse when the count reaches 0
- warn  out  1  high while RUNNING/PAUSED and secs_remaining ≤ WARN_SECS

Behaviour:
- Reset:
  - state IDLE; secs_remaining = DEFAULT_SECS; digits match DEFAULT_SECS (60 → 1,0,0).
  - running, expired, done_pulse, warn all 0.
  - start/pause edge-detect registers and blink edge register cleared.
  - Reset mid-run abandons the count immediately.
- Edge detection: start_rise and pause_rise are derived from a one-cycle-delayed copy of each input. A level held high produces one event only.
- States: IDLE, RUNNING, PAUSED, EXPIRED.
  - IDLE → RUNNING on start_rise, if secs_remaining ≠ 0.
  - RUNNING ↔ PAUSED on pause_rise.
  - RUNNING → EXPIRED when a tick decrements 1 → 0.
  - PAUSED → RUNNING on start_rise or pause_rise.
  - EXPIRED → IDLE on load.
  - start_rise in EXPIRED is ignored.
- Load:
  - Accepted in IDLE and EXPIRED only; ignored in RUNNING and PAUSED.
  - The loaded value is min(load_secs, MAX_SECS); load_secs = 0 loads DEFAULT_SECS.
  - The value is visible on secs_remaining the cycle after the strobe.
- Decrement:
  - tick_1hz sampled high in RUNNING at edge N → secs_remaining decrements at edge N.
  - Ticks in IDLE, PAUSED or EXPIRED are ignored.
  - No underflow: the count saturates at 0.
- Simultaneous events:
  - start_rise and tick in the same IDLE cycle: enter RUNNING; that tick does not decrement.
  - pause_rise and tick in RUNNING: pause wins, no decrement.
  - load and start in IDLE: load wins and the state stays IDLE.
- Expiry:
  - On the 1 → 0 decrement edge, secs_remaining = 0, the state becomes EXPIRED and done_pulse = 1 for exactly that cycle.
  - expired stays high until load or reset.
- Digits:
  - Registered and updated on the same edge as secs_remaining; they always agree with it.
  - Maintained as cascaded down-counters: ones 0 → 9 with borrow; tens 0 → 5 with borrow; minutes decrement on borrow.
  - On load, digits are derived from the loaded value; a multi-cycle conversion is not permitted.
- warn: registered; asserted on the edge where secs_remaining becomes ≤ WARN_SECS; forced 0 in IDLE/EXPIRED.

Optional Feature:
- Macro: TIMER_BLINK_EN.
- Defined:
  - Adds output blank (1 bit, reset 0).
  - While warn = 1, each blink_toggle edge (either direction, detected by a delayed register) inverts blank.
  - blank is forced 0 when warn = 0 and in PAUSED.
  - In EXPIRED, blank toggles on each blink_toggle edge, so the zero display flashes.
- Not defined: the port is absent, and blink_toggle is unused, with no logic synthesized.

Test Plan:
- Reset, then start pulse, then 3 tick_1hz pulses → secs_remaining 60 → 57; digits 0,5,7; running = 1.
- load_secs = 5, start, 5 ticks → done_pulse high exactly one cycle on the 5th tick edge; expired = 1; a 6th tick leaves secs_remaining at 0.
- load_secs = 700 → secs_remaining = 599, digits 9,5,9. load_secs = 0 → 60. Load while RUNNING → ignored.
- RUNNING at 30, pause rise with a tick in the same cycle → 30, PAUSED; 4 ticks → still 30; start rise → RUNNING; next tick → 29.
- Count 100 (1,4,0), one tick → 99 (1,3,9); 60 → 59 (0,5,9). warn asserts on the edge where the count reaches 10.
- TIMER_BLINK_EN: at 8 s remaining, 4 blink_toggle edges → blank toggles 4 times; pause → blank = 0.
